// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: five-stage pipeline sequencing with RAW bubbles, redirect squash, memory hold and saturating event counters
module pipeline_ctrl #(
    parameter int REGISTER_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REGISTER_WIDTH-1:0] dec_ra_i,
    input  logic                      dec_ra_used_i,
    input  logic [REGISTER_WIDTH-1:0] dec_rb_i,
    input  logic                      dec_rb_used_i,
    input  logic                      dec_wr_en_i,
    input  logic [REGISTER_WIDTH-1:0] dec_wr_reg_i,
    input  logic                      redirect_i,
    input  logic                      mem_busy_i,
    output logic                      fetch_en_o,
    output logic                      alu_en_o,
    output logic                      mem_en_o,
    output logic                      id_valid_o,
    output logic                      alu_valid_o,
    output logic                      mem_valid_o,
    output logic                      wb_valid_o,
    output logic                      stall_o,
    output logic                      flush_o,
    output logic                      rf_wr_en_o,
    output logic [REGISTER_WIDTH-1:0] rf_wr_reg_o,
    output logic                      commit_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o,
    output logic [CNT_WIDTH-1:0]      flush_cnt_o
);
    logic                      v_id, v_alu, v_mem, v_wb;
    logic                      alu_we, mem_we, wb_we;
    logic [REGISTER_WIDTH-1:0] alu_reg, mem_reg, wb_reg;
    logic                      ra_hit, rb_hit, hazard;

    // No forwarding: any valid in-flight writer of a used source blocks ID until it has left WB.
    always_comb begin
        ra_hit     = (v_alu && alu_we && alu_reg == dec_ra_i) ||
                     (v_mem && mem_we && mem_reg == dec_ra_i) ||
                     (v_wb  && wb_we  && wb_reg  == dec_ra_i);
        rb_hit     = (v_alu && alu_we && alu_reg == dec_rb_i) ||
                     (v_mem && mem_we && mem_reg == dec_rb_i) ||
                     (v_wb  && wb_we  && wb_reg  == dec_rb_i);
        hazard     = v_id && ((dec_ra_used_i && ra_hit) || (dec_rb_used_i && rb_hit));
        flush_o    = !mem_busy_i && redirect_i && v_alu;
        stall_o    = !mem_busy_i && !flush_o && hazard;
        fetch_en_o = !mem_busy_i && !stall_o;
        alu_en_o   = !mem_busy_i;
        mem_en_o   = !mem_busy_i;
    end

    assign id_valid_o  = v_id;
    assign alu_valid_o = v_alu;
    assign mem_valid_o = v_mem;
    assign wb_valid_o  = v_wb;
    assign commit_o    = v_wb;
    assign rf_wr_en_o  = v_wb && wb_we;
    assign rf_wr_reg_o = wb_reg;

    // A stall keeps v_id at 1 because a hazard implies an occupied ID, so only a flush clears it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {v_id, v_alu, v_mem, v_wb} <= '0;
            {alu_we, mem_we, wb_we}    <= '0;
            alu_reg <= '0;
            mem_reg <= '0;
            wb_reg  <= '0;
        end else if (mem_busy_i) begin
            v_wb <= 1'b0;
        end else begin
            v_id    <= !flush_o;
            v_alu   <= v_id && !flush_o && !stall_o;
            alu_we  <= dec_wr_en_i;
            alu_reg <= dec_wr_reg_i;
            v_mem   <= v_alu;
            mem_we  <= alu_we;
            mem_reg <= alu_reg;
            v_wb    <= v_mem;
            wb_we   <= mem_we;
            wb_reg  <= mem_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            stall_cnt_o <= (stall_o && stall_cnt_o != '1) ? stall_cnt_o + CNT_WIDTH'(1) : stall_cnt_o;
            flush_cnt_o <= (flush_o && flush_cnt_o != '1) ? flush_cnt_o + CNT_WIDTH'(1) : flush_cnt_o;
        end
    end
endmodule
